// File: rtl/sense_pkg.sv
// sense_pkg: shared state encoding, counter type and default timing
// constants for the atrial/ventricular sense conditioner.
package sense_pkg;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_BLANK_CYC    = 16;
    localparam int DEF_REFRACT_CYC  = 64;
    localparam int DEF_XBLANK_CYC   = 8;

    typedef enum logic [1:0] {
        LISTEN = 2'd0,
        QUAL   = 2'd1,
        REFR   = 2'd2,
        BLANK  = 2'd3
    } sense_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == cnt_t'(CNT_MAX)) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/sense_channel.sv
// sense_channel: one chamber of the sense conditioner. A 2-flop
// synchronizer feeds a debounce/refractory/blanking FSM sharing a single
// 8-bit saturating counter. Sense pulse and refractory flag are registered.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   LISTEN | idle, waiting for the synchronized level to go high
//   QUAL   | level high, counting consecutive high samples
//   REFR   | sense delivered, ignore input for REFRACT_CYC cycles
//   BLANK  | pace delivered, ignore input for the blanking window
//
// A blank triggered by the own-chamber pace lasts BLANK_CYC cycles; one
// triggered by the cross-chamber pace (xpace) lasts XBLANK_CYC cycles.
// Own pace wins when both arrive together. REFR and BLANK only release to
// LISTEN once the window has elapsed and the input is low, so a level that
// stays high never produces a second pulse.
module sense_channel
    import sense_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int REFRACT_CYC  = DEF_REFRACT_CYC,
    parameter int XBLANK_CYC   = DEF_XBLANK_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic pace,
    input  logic xpace,
    output logic sense,
    output logic refr
);

    if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > CNT_MAX) begin : g_bad_debounce
        $error("sense_channel: DEBOUNCE_CYC=%0d outside 1..%0d", DEBOUNCE_CYC, CNT_MAX);
    end
    if (BLANK_CYC < 1 || BLANK_CYC > CNT_MAX) begin : g_bad_blank
        $error("sense_channel: BLANK_CYC=%0d outside 1..%0d", BLANK_CYC, CNT_MAX);
    end
    if (REFRACT_CYC < 1 || REFRACT_CYC > CNT_MAX) begin : g_bad_refract
        $error("sense_channel: REFRACT_CYC=%0d outside 1..%0d", REFRACT_CYC, CNT_MAX);
    end
    if (XBLANK_CYC < 1 || XBLANK_CYC > CNT_MAX) begin : g_bad_xblank
        $error("sense_channel: XBLANK_CYC=%0d outside 1..%0d", XBLANK_CYC, CNT_MAX);
    end

    // The counter is cleared on entry to REFR/BLANK, so the window has
    // elapsed once the counter reaches length-1.
    localparam cnt_t DEB_L       = cnt_t'(DEBOUNCE_CYC);
    localparam cnt_t REFR_LAST   = cnt_t'(REFRACT_CYC - 1);
    localparam cnt_t BLANK_LAST  = cnt_t'(BLANK_CYC - 1);
    localparam cnt_t XBLANK_LAST = cnt_t'(XBLANK_CYC - 1);

    logic         sync1_q, sync1_d;
    logic         sync2_q, sync2_d;
    sense_state_e state_q, state_d;
    cnt_t         cnt_q, cnt_d;
    cnt_t         blank_last_q, blank_last_d;
    logic         sense_q, sense_d;
    logic         refr_q, refr_d;

    logic s;
    logic any_pace;

    assign s        = sync2_q;
    assign any_pace = pace | xpace;

    // State register: synchronizer, FSM state, counter, blank length, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= LISTEN;
            cnt_q        <= '0;
            blank_last_q <= '0;
            sense_q      <= 1'b0;
            refr_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blank_last_q <= blank_last_d;
            sense_q      <= sense_d;
            refr_q       <= refr_d;
        end
    end

    // Next-state logic: any pace preempts every state, otherwise walk the FSM.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        blank_last_d = blank_last_q;
        if (any_pace) begin
            state_d      = BLANK;
            cnt_d        = '0;
            blank_last_d = pace ? BLANK_LAST : XBLANK_LAST;
        end else begin
            case (state_q)
                LISTEN: begin
                    if (s) begin
                        state_d = QUAL;
                        cnt_d   = cnt_t'(1);
                    end
                end
                QUAL: begin
                    if (!s) begin
                        state_d = LISTEN;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_L) begin
                        state_d = REFR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat_inc(cnt_q);
                    end
                end
                REFR: begin
                    if (cnt_q >= REFR_LAST && !s) begin
                        state_d = LISTEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat_inc(cnt_q);
                    end
                end
                BLANK: begin
                    if (cnt_q >= blank_last_q && !s) begin
                        state_d = LISTEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = LISTEN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: one-cycle sense on qualification (a pace vetoes it), and a
    // refractory flag that follows the current state one cycle later.
    always_comb begin
        sense_d = (state_q == QUAL) && s && (cnt_q >= DEB_L) && !any_pace;
        refr_d  = (state_q == REFR) || (state_q == BLANK);
    end

    assign sense = sense_q;
    assign refr  = refr_q;

endmodule

// File: rtl/sense_conditioner.sv
// sense_conditioner: atrial and ventricular sense conditioning for the
// pacemaker controller. Two identical sense_channel instances; the top only
// wires them up and optionally routes the atrial pace into the ventricular
// channel as a cross-blanking trigger.
//
// Build option: define VCROSS_BLANK_EN to enable ventricular cross-blanking
// (pa blanks the V channel for XBLANK_CYC cycles). Without it pa affects
// only the A channel.
module sense_conditioner
    import sense_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int REFRACT_CYC  = DEF_REFRACT_CYC,
    parameter int XBLANK_CYC   = DEF_XBLANK_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_v,
    input  logic pa,
    input  logic pv,
    output logic sa,
    output logic sv,
    output logic a_refr,
    output logic v_refr
);

    logic v_xpace;

`ifdef VCROSS_BLANK_EN
    assign v_xpace = pa;
`else
    assign v_xpace = 1'b0;
`endif

    sense_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .BLANK_CYC    (BLANK_CYC),
        .REFRACT_CYC  (REFRACT_CYC),
        .XBLANK_CYC   (XBLANK_CYC)
    ) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_a),
        .pace  (pa),
        .xpace (1'b0),
        .sense (sa),
        .refr  (a_refr)
    );

    sense_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .BLANK_CYC    (BLANK_CYC),
        .REFRACT_CYC  (REFRACT_CYC),
        .XBLANK_CYC   (XBLANK_CYC)
    ) u_chan_v (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_v),
        .pace  (pv),
        .xpace (v_xpace),
        .sense (sv),
        .refr  (v_refr)
    );

endmodule

// File: tb/tb_sense_conditioner.sv
// tb_sense_conditioner: scoreboard bench. Each driven cycle pushes the
// reference model's prediction; a monitor pops and compares after the edge.
// Directed scenarios exercise the documented timing cases, then random
// stimulus runs against the same model.
module tb_sense_conditioner;

    localparam int DEB  = 4;
    localparam int BLK  = 16;
    localparam int REF  = 64;
    localparam int XBLK = 8;

    logic clk = 1'b0;
    logic rst, raw_a, raw_v, pa, pv;
    logic sa, sv, a_refr, v_refr;

    always #5 clk = ~clk;

    sense_conditioner #(
        .DEBOUNCE_CYC (DEB),
        .BLANK_CYC    (BLK),
        .REFRACT_CYC  (REF),
        .XBLANK_CYC   (XBLK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_a  (raw_a),
        .raw_v  (raw_v),
        .pa     (pa),
        .pv     (pv),
        .sa     (sa),
        .sv     (sv),
        .a_refr (a_refr),
        .v_refr (v_refr)
    );

    typedef struct {
        int   cyc;
        logic sa;
        logic sv;
        logic ar;
        logic vr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   t_edge = 0;

    // Reference model, per chamber: deaf = ignoring input (refractory or
    // blanked) since edge m_start for at least m_len edges; m_run = number of
    // consecutive high synchronized samples while listening; m_h0/m_h1 =
    // raw level seen one and two edges ago.
    bit m_deaf  [2];
    int m_start [2];
    int m_len   [2];
    int m_run   [2];
    bit m_h0    [2];
    bit m_h1    [2];

    logic obs_sa, obs_sv, obs_ar, obs_vr;

    function automatic void chk_bit(input string name, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_ch(input int ch, input bit raw, input bit own, input bit xp,
                                     input bit r, output bit sense, output bit refr);
        bit s;
        sense = 1'b0;
        refr  = 1'b0;
        if (r) begin
            m_deaf[ch] = 1'b0;
            m_run[ch]  = 0;
            m_h0[ch]   = 1'b0;
            m_h1[ch]   = 1'b0;
            return;
        end
        s    = m_h1[ch];
        refr = m_deaf[ch];
        if (own || xp) begin
            m_deaf[ch]  = 1'b1;
            m_start[ch] = t_edge;
            m_len[ch]   = own ? BLK : XBLK;
            m_run[ch]   = 0;
        end else if (m_deaf[ch]) begin
            if ((t_edge - m_start[ch]) >= m_len[ch] && !s) m_deaf[ch] = 1'b0;
        end else if (s) begin
            m_run[ch]++;
            if (m_run[ch] > DEB) begin
                sense       = 1'b1;
                m_deaf[ch]  = 1'b1;
                m_start[ch] = t_edge;
                m_len[ch]   = REF;
                m_run[ch]   = 0;
            end
        end else begin
            m_run[ch] = 0;
        end
        m_h1[ch] = m_h0[ch];
        m_h0[ch] = raw;
    endfunction

    // Drive one clock edge's inputs, record the prediction, then capture the
    // outputs the DUT shows after that edge for the directed checks.
    task automatic cyc(input bit ra, input bit rv, input bit p_a, input bit p_v, input bit r);
        exp_t e;
        bit   s_a, r_a, s_v, r_v, xp;
        @(negedge clk);
        raw_a = ra;
        raw_v = rv;
        pa    = p_a;
        pv    = p_v;
        rst   = r;
`ifdef VCROSS_BLANK_EN
        xp = p_a;
`else
        xp = 1'b0;
`endif
        t_edge++;
        model_ch(0, ra, p_a, 1'b0, r, s_a, r_a);
        model_ch(1, rv, p_v, xp, r, s_v, r_v);
        e.cyc = t_edge;
        e.sa  = s_a;
        e.sv  = s_v;
        e.ar  = r_a;
        e.vr  = r_v;
        sb.push_back(e);
        @(posedge clk);
        #2;
        obs_sa = sa;
        obs_sv = sv;
        obs_ar = a_refr;
        obs_vr = v_refr;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare every output against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_bit("sb_sa",     e.cyc, sa,     e.sa);
                chk_bit("sb_sv",     e.cyc, sv,     e.sv);
                chk_bit("sb_a_refr", e.cyc, a_refr, e.ar);
                chk_bit("sb_v_refr", e.cyc, v_refr, e.vr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_sa, n_sv, n_vr;
        bit lvl [2];
        int rem [2];

        rst = 1'b1; raw_a = 1'b0; raw_v = 1'b0; pa = 1'b0; pv = 1'b0;

        // Reset state.
        do_reset();
        chk_bit("reset_sa", 0, obs_sa, 1'b0);
        chk_bit("reset_sv", 0, obs_sv, 1'b0);
        chk_bit("reset_a_refr", 0, obs_ar, 1'b0);
        chk_bit("reset_v_refr", 0, obs_vr, 1'b0);

        // raw_a high edges 10..29: one pulse at 16, a_refr 17..80.
        n_sa = 0;
        for (int e = 0; e < 100; e++) begin
            cyc(e >= 10 && e < 30, 1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_sa) n_sa++;
            if (e == 15) chk_bit("basic_sa_early", e, obs_sa, 1'b0);
            if (e == 16) chk_bit("basic_sa_pulse", e, obs_sa, 1'b1);
            if (e == 16) chk_bit("basic_refr_pre", e, obs_ar, 1'b0);
            if (e == 17) chk_bit("basic_refr_rise", e, obs_ar, 1'b1);
            if (e == 80) chk_bit("basic_refr_last", e, obs_ar, 1'b1);
            if (e == 81) chk_bit("basic_refr_fall", e, obs_ar, 1'b0);
        end
        chk_int("basic_sa_count", n_sa, 1);

        // Short 3-cycle glitch on raw_v is rejected; later a real sense still fires.
        do_reset();
        n_sv = 0; n_vr = 0;
        for (int e = 0; e < 40; e++) begin
            cyc(1'b0, (e >= 5 && e < 8) || (e >= 20 && e < 30), 1'b0, 1'b0, 1'b0);
            if (obs_sv) n_sv++;
            if (obs_vr && e < 20) n_vr++;
            if (e == 26) chk_bit("glitch_then_sv", e, obs_sv, 1'b1);
        end
        chk_int("glitch_sv_count", n_sv, 1);
        chk_int("glitch_v_refr", n_vr, 0);

        // pv at 20 blanks raw_v 25..30; raw_v from 40 senses at 46.
        do_reset();
        n_sv = 0;
        for (int e = 0; e < 60; e++) begin
            cyc(1'b0, (e >= 25 && e <= 30) || (e >= 40 && e < 55), 1'b0, e == 20, 1'b0);
            if (obs_sv) n_sv++;
            if (e == 21) chk_bit("blank_v_refr", e, obs_vr, 1'b1);
            if (e == 46) chk_bit("blank_then_sv", e, obs_sv, 1'b1);
        end
        chk_int("blank_sv_count", n_sv, 1);

        // pa on the qualifying edge: no sense, 16-cycle blank.
        do_reset();
        n_sa = 0;
        for (int e = 0; e < 50; e++) begin
            cyc(e >= 10 && e < 15, 1'b0, e == 16, 1'b0, 1'b0);
            if (obs_sa) n_sa++;
            if (e == 17) chk_bit("pace_win_refr_rise", e, obs_ar, 1'b1);
            if (e == 32) chk_bit("pace_win_refr_last", e, obs_ar, 1'b1);
            if (e == 33) chk_bit("pace_win_refr_fall", e, obs_ar, 1'b0);
        end
        chk_int("pace_win_sa_count", n_sa, 0);

        // Reset in REFR aborts; fresh qualification 6 cycles after release.
        do_reset();
        n_sa = 0;
        for (int e = 0; e < 30; e++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, e == 9);
            if (obs_sa) n_sa++;
            if (e == 6)  chk_bit("rst_mid_first_sa", e, obs_sa, 1'b1);
            if (e == 9)  chk_bit("rst_mid_sa_zero", e, obs_sa, 1'b0);
            if (e == 9)  chk_bit("rst_mid_refr_zero", e, obs_ar, 1'b0);
            if (e == 15) chk_bit("rst_mid_sa_early", e, obs_sa, 1'b0);
            if (e == 16) chk_bit("rst_mid_sa_again", e, obs_sa, 1'b1);
        end
        chk_int("rst_mid_sa_count", n_sa, 2);

        // pa at 0 with raw_v high 2..7: cross-blanked only when enabled.
        do_reset();
        n_sv = 0;
        for (int e = 0; e < 30; e++) begin
            cyc(1'b0, e >= 2 && e <= 7, e == 0, 1'b0, 1'b0);
            if (obs_sv) n_sv++;
`ifdef VCROSS_BLANK_EN
            if (e == 1) chk_bit("xblank_v_refr", e, obs_vr, 1'b1);
`else
            if (e == 1) chk_bit("xblank_v_refr", e, obs_vr, 1'b0);
            if (e == 8) chk_bit("xblank_sv", e, obs_sv, 1'b1);
`endif
        end
`ifdef VCROSS_BLANK_EN
        chk_int("xblank_sv_count", n_sv, 0);
`else
        chk_int("xblank_sv_count", n_sv, 1);
`endif

        // Random traffic: variable-length raw bursts, sparse paces, rare resets.
        do_reset();
        for (int ch = 0; ch < 2; ch++) begin
            lvl[ch] = 1'b0;
            rem[ch] = 0;
        end
        for (int i = 0; i < 4000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    if (lvl[ch])
                        rem[ch] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 120))
                                                              : int'($urandom_range(1, 9));
                    else
                        rem[ch] = int'($urandom_range(1, 30));
                end
                rem[ch]--;
            end
            cyc(lvl[0], lvl[1], $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 999) == 0);
        end

        chk_int("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
